bin_to_bcd3_seq: RTL and testbench



---
 rtl/bcd_pkg.sv | 18 +
 rtl/bcd_add3_digit.sv | 11 +
 rtl/bin_to_bcd3_seq.sv | 97 +++++++++
 tb/tb_bin_to_bcd3_seq.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD datapath.
package bcd_pkg;

   typedef logic [3:0] bcd_digit_t;

   typedef enum logic {IDLE, SHIFT} conv_state_t;

   localparam bcd_digit_t BCD_NINE = 4'd9;

   // Largest value representable in 'digits' BCD digits (10^digits - 1).
   function automatic int unsigned bcd_max(input int unsigned digits);
      int unsigned r;
      r = 1;
      for (int unsigned i = 0; i < digits; i++) r = r * 10;
      return r - 1;
   endfunction

endpackage

// File: rtl/bcd_add3_digit.sv
// Per-digit double-dabble correction: digits of 5 or more get +3 before the shift.
module bcd_add3_digit
   import bcd_pkg::*;
(
   input  bcd_digit_t din,
   output bcd_digit_t dout
);

   assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/bin_to_bcd3_seq.sv
// Sequential binary-to-BCD converter, one bit per clock (shift-and-add-3).
// Operands above the BCD range saturate to all nines and raise ovf.
module bin_to_bcd3_seq
   import bcd_pkg::*;
#(
   parameter int BIN_W  = 10,
   parameter int DIGITS = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [BIN_W-1:0]      bin,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  ovf
);

   localparam int              CNT_W   = $clog2(BIN_W + 1);
   localparam logic [BIN_W-1:0] MAX_VAL = BIN_W'(bcd_max(DIGITS));

   conv_state_t             state, state_nxt;
   logic                    accept, finish;
   logic [BIN_W-1:0]        sreg;
   logic [4*DIGITS-1:0]     scratch, scratch_adj;
   logic [CNT_W-1:0]        cnt;
   logic                    ovf_next;

   // Per-digit +3 correction applied to the scratch before every shift.
   for (genvar g = 0; g < DIGITS; g++) begin : g_add3
      bcd_add3_digit u_add3 (
         .din  (scratch[4*g +: 4]),
         .dout (scratch_adj[4*g +: 4])
      );
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next state: accept start only when idle; leave SHIFT once all bits are consumed.
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      finish    = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               accept    = 1'b1;
               state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            if (cnt == '0) begin
               finish    = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath: load operand, shift BIN_W times, then publish the (possibly saturated) result.
   always_ff @(posedge clk) begin
      if (rst) begin
         sreg     <= '0;
         scratch  <= '0;
         cnt      <= '0;
         ovf_next <= 1'b0;
         bcd      <= '0;
         ovf      <= 1'b0;
         done     <= 1'b0;
         busy     <= 1'b0;
      end else begin
         done <= 1'b0;
         if (accept) begin
            sreg     <= bin;
            scratch  <= '0;
            cnt      <= CNT_W'(BIN_W);
            ovf_next <= (bin > MAX_VAL);
            busy     <= 1'b1;
         end else if (finish) begin
            // Scratch is meaningless for out-of-range operands; saturation replaces it.
            bcd  <= ovf_next ? {DIGITS{BCD_NINE}} : scratch;
            ovf  <= ovf_next;
            done <= 1'b1;
            busy <= 1'b0;
         end else if (state == SHIFT) begin
            {scratch, sreg} <= {scratch_adj, sreg} << 1;
            cnt             <= cnt - CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_bin_to_bcd3_seq.sv
// Self-checking bench for bin_to_bcd3_seq: vector table plus scoreboard queue.
module tb_bin_to_bcd3_seq;

   logic        clk = 1'b0;
   logic        rst, start, busy, done, ovf;
   logic [9:0]  bin;
   logic [11:0] bcd;
   logic [11:0] inc_y;
   logic        prev_done = 1'b0;

   typedef struct {
      logic [9:0]  b;
      logic [11:0] e_bcd;
      logic        e_ovf;
   } vec_t;

   typedef struct packed {
      logic [11:0] bcd;
      logic        ovf;
   } res_t;

   res_t q[$];
   vec_t tbl[8];
   int   n_checks = 0;
   int   n_fail   = 0;

   bin_to_bcd3_seq #(.BIN_W(10), .DIGITS(3)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .bin   (bin),
      .busy  (busy),
      .done  (done),
      .bcd   (bcd),
      .ovf   (ovf)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference conversion by decimal arithmetic.
   function automatic res_t model(input logic [9:0] b);
      res_t r;
      int   v;
      v = int'(b);
      if (v > 999) begin
         r.bcd = 12'h999;
         r.ovf = 1'b1;
      end else begin
         r.bcd = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
         r.ovf = 1'b0;
      end
      return r;
   endfunction

   // Downstream BCD incrementor model (mod 1000).
   function automatic logic [11:0] bcd_inc(input logic [11:0] x);
      logic [11:0] y;
      logic        c;
      y = x;
      c = 1'b1;
      for (int d = 0; d < 3; d++) begin
         if (c) begin
            if (y[4*d +: 4] == 4'd9) y[4*d +: 4] = 4'd0;
            else begin
               y[4*d +: 4] = y[4*d +: 4] + 4'd1;
               c = 1'b0;
            end
         end
      end
      return y;
   endfunction

   always @(posedge clk) inc_y <= bcd_inc(bcd);

   // Scoreboard: every done pops one expected result; done must be a single-cycle strobe.
   always @(negedge clk) begin
      if (done) begin
         n_checks++;
         if (prev_done) begin
            n_fail++;
            $display("FAIL done_width: done high two cycles at %0t", $time);
         end
         if (q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_done: bcd=%0h with no pending conversion at %0t", bcd, $time);
         end else begin
            res_t e;
            e = q.pop_front();
            check("sb_bcd", 32'(bcd), 32'(e.bcd));
            check("sb_ovf", 32'(ovf), 32'(e.ovf));
         end
      end
      prev_done = done;
   end

   // Called #1 after a posedge. Launches one conversion, optionally glitches start
   // while busy, and returns #1 after the edge that raises done.
   task automatic run_conv(input logic [9:0] b, input res_t e, input int glitch_at);
      int lat;
      int busy_err;
      start = 1'b1;
      bin   = b;
      q.push_back(e);
      @(posedge clk); #1;
      start = 1'b0;
      bin   = ~b;
      lat      = 0;
      busy_err = 0;
      while (!done && lat < 20) begin
         if (!busy) busy_err++;
         start = (lat == glitch_at - 1);
         if (start) bin = 10'd5;
         @(posedge clk); #1;
         lat++;
      end
      start = 1'b0;
      check("latency", 32'(lat), 32'd11);
      check("busy_while_converting", 32'(busy_err), 32'd0);
      check("busy_low_in_done", 32'(busy), 32'd0);
   endtask

   initial begin
      int ndone;
      tbl[0] = '{10'd0,    12'h000, 1'b0};
      tbl[1] = '{10'd459,  12'h459, 1'b0};
      tbl[2] = '{10'd9,    12'h009, 1'b0};
      tbl[3] = '{10'd999,  12'h999, 1'b0};
      tbl[4] = '{10'd1000, 12'h999, 1'b1};
      tbl[5] = '{10'd1023, 12'h999, 1'b1};
      tbl[6] = '{10'd123,  12'h123, 1'b0};
      tbl[7] = '{10'd99,   12'h099, 1'b0};

      rst = 1'b1; start = 1'b0; bin = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_bcd",  32'(bcd),  32'd0);
      check("rst_ovf",  32'(ovf),  32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Table vectors, back-to-back: each next start lands in the previous done cycle.
      for (int i = 0; i < 8; i++) begin
         res_t e;
         e.bcd = tbl[i].e_bcd;
         e.ovf = tbl[i].e_ovf;
         run_conv(tbl[i].b, e, 0);
      end
      // Downstream incrementor sees 099 and produces 100 one clock after done.
      @(posedge clk); #1;
      check("incrementor_y", 32'(inc_y), 32'h100);

      // Random operands across the full input range.
      repeat (6) begin
         logic [9:0] b;
         b = 10'($urandom_range(0, 1023));
         run_conv(b, model(b), 0);
      end

      // Start while busy is ignored.
      @(posedge clk); #1;
      run_conv(10'd890, model(10'd890), 4);
      repeat (15) @(posedge clk);
      #1;

      // Reset mid-conversion aborts with no done.
      start = 1'b1; bin = 10'd199;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_bcd",  32'(bcd),  32'd0);
      check("abort_ovf",  32'(ovf),  32'd0);
      check("abort_done", 32'(done), 32'd0);
      rst = 1'b0;
      ndone = 0;
      repeat (15) begin
         @(posedge clk); #1;
         if (done) ndone++;
      end
      check("abort_no_done", 32'(ndone), 32'd0);

      // Reset and start together: reset wins.
      rst = 1'b1; start = 1'b1; bin = 10'd7;
      @(posedge clk); #1;
      check("rst_vs_start_busy", 32'(busy), 32'd0);
      rst = 1'b0; start = 1'b0;
      repeat (15) @(posedge clk);
      #1;

      check("pending_results", 32'(q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
